// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared width, opcode encodings and flag bit positions for the ALU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int ALU_WIDTH = 64;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLL  = 3'b101;
  localparam logic [2:0] OP_SRL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_W     = 3;

endpackage

`default_nettype wire

// File: rtl/alu_exec.sv
// ============================================================================
// Module : alu_exec
// Brief  : Combinational execute stage: op units plus result/flag select.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);

  localparam int SH_W = $clog2(WIDTH);

  logic             w_is_sub;
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_xor;
  logic [SH_W-1:0]  w_sh;

  // SUB shares the adder as a + ~b + 1, so carry reads as "no borrow"
  assign w_is_sub = (op == OP_SUB);
  assign w_bx     = w_is_sub ? ~b : b;
  assign w_sum    = {1'b0, a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_is_sub};
  assign w_sh     = b[SH_W-1:0];

  xor_op #(
    .WIDTH (WIDTH)
  ) u_xor_op (
    .a (a),
    .b (b),
    .y (w_xor)
  );

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result = w_sum[WIDTH-1:0];
        carry  = w_sum[WIDTH];
        ovf    = (a[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = w_xor;
      OP_SLL:  result = a << w_sh;
      OP_SRL:  result = a >> w_sh;
      default: result = a;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/xor_op.sv
// ============================================================================
// Module : xor_op
// Brief  : Bitwise XOR operation unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module xor_op #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a ^ b;

endmodule

`default_nettype wire

// File: rtl/alu_issue_pipe.sv
// ============================================================================
// Module : alu_issue_pipe
// Brief  : Two-stage valid/ready ALU front end (operand register, result register).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_issue_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_ovf,
  output logic [CNT_W-1:0] op_count
);

  logic              r_s1_valid;
  logic [2:0]        r_s1_op;
  logic [WIDTH-1:0]  r_s1_a;
  logic [WIDTH-1:0]  r_s1_b;
  logic              r_s2_valid;
  logic [WIDTH-1:0]  r_result;
  logic [FLAG_W-1:0] r_flags;
  logic [CNT_W-1:0]  r_op_count;

  logic              w_s2_adv;
  logic              w_accept;
  logic [WIDTH-1:0]  w_result;
  logic              w_carry;
  logic              w_ovf;

  // S1 drains whenever S2 drains, so a full pipe still accepts during an output handshake
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_adv;
  assign w_accept = in_valid && in_ready;

  alu_exec #(
    .WIDTH (WIDTH)
  ) u_alu_exec (
    .op     (r_s1_op),
    .a      (r_s1_a),
    .b      (r_s1_b),
    .result (w_result),
    .carry  (w_carry),
    .ovf    (w_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_op    <= in_op;
      r_s1_a     <= in_a;
      r_s1_b     <= in_b;
    end else if (w_s2_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_flags    <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid          <= r_s1_valid;
      r_result            <= w_result;
      r_flags[FLAG_ZERO]  <= (w_result == '0);
      r_flags[FLAG_CARRY] <= w_carry;
      r_flags[FLAG_OVF]   <= w_ovf;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op_count <= '0;
    end else if (w_accept) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_result;
  assign out_zero   = r_flags[FLAG_ZERO];
  assign out_carry  = r_flags[FLAG_CARRY];
  assign out_ovf    = r_flags[FLAG_OVF];
  assign op_count   = r_op_count;

endmodule

`default_nettype wire
